poly_tone_synth: RTL and testbench

// Polyphonic square-wave tone source for the piano datapath: one oscillator per key, per-key linear

---
 rtl/poly_tone_synth.sv | 204 ++++++++++++++++++++
 tb/tb_poly_tone_synth.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/poly_tone_synth.sv
// ---------------------------------------------------------------------------
// poly_tone_synth
// Polyphonic square-wave tone source. Each key has its own oscillator and a
// linear attack/release envelope. All voices are mixed with saturation, and
// the mix is handed to the audio controller at a fixed sample rate.
//
// Ports
//   CLOCK_50                in   system clock
//   resetn                  in   asynchronous reset, active low
//   keys                    in   raw key levels (asynchronous, 1 = pressed)
//   audio_out_allowed       in   audio controller FIFO has space
//   left_channel_audio_out  out  current sample (signed)
//   right_channel_audio_out out  same value as the left channel
//   write_audio_out         out  one-cycle write strobe
//   overrun                 out  sticky flag: a sample was dropped before it was written
//   active_voices           out  one bit per key, set while that key's gain is non-zero
// ---------------------------------------------------------------------------
module poly_tone_synth #(
    parameter int N_KEYS     = 10,
    parameter int HP_W       = 19,
    parameter logic [N_KEYS*HP_W-1:0] HALF_PERIODS = {
        19'd37922, 19'd42568, 19'd47778, 19'd50620, 19'd56818,
        19'd63775, 19'd71586, 19'd75842, 19'd85132, 19'd95554},
    parameter int ENV_W      = 8,
    parameter int ENV_STEP   = 1024,
    parameter int AMP_SHIFT  = 15,
    parameter int SAMPLE_W   = 32,
    parameter int SAMPLE_DIV = 1042
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [N_KEYS-1:0]   keys,
    input  logic                audio_out_allowed,
    output logic [SAMPLE_W-1:0] left_channel_audio_out,
    output logic [SAMPLE_W-1:0] right_channel_audio_out,
    output logic                write_audio_out,
    output logic                overrun,
    output logic [N_KEYS-1:0]   active_voices
);

    localparam int STEP_W = (ENV_STEP > 1) ? $clog2(ENV_STEP) : 1;
    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    // Headroom so that the sum of all voices can never wrap before clamping.
    localparam int MIX_W  = SAMPLE_W + $clog2(N_KEYS) + 1;

    localparam logic [ENV_W-1:0] GAIN_MAX = {ENV_W{1'b1}};
    localparam logic signed [MIX_W-1:0] SAT_MAX =
        {{(MIX_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [MIX_W-1:0] SAT_MIN =
        {{(MIX_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Key synchroniser
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] keys_meta_q;
    logic [N_KEYS-1:0] keys_s_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            keys_meta_q <= '0;
            keys_s_q    <= '0;
        end else begin
            keys_meta_q <= keys;
            keys_s_q    <= keys_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Shared envelope step timer
    // ------------------------------------------------------------------
    logic [STEP_W-1:0] step_cnt_q;
    logic              step_stb;

    assign step_stb = (step_cnt_q == STEP_W'(ENV_STEP - 1));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            step_cnt_q <= '0;
        end else if (step_stb) begin
            step_cnt_q <= '0;
        end else begin
            step_cnt_q <= step_cnt_q + STEP_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-key voices: envelope, oscillator, signed contribution
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0][MIX_W-1:0] contrib;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_voice
        localparam logic [HP_W-1:0] HP = HALF_PERIODS[k*HP_W +: HP_W];
        localparam bit HP_ZERO = (HP == '0);

        logic [ENV_W-1:0] gain_q, gain_d;
        logic [HP_W-1:0]  cnt_q;
        logic             phase_q;
        logic [MIX_W-1:0] level;

        // Gain saturates at both ends so the envelope can never wrap.
        always_comb begin
            gain_d = gain_q;
            if (step_stb) begin
                if (keys_s_q[k]) begin
                    if (gain_q != GAIN_MAX) gain_d = gain_q + ENV_W'(1);
                end else if (gain_q != '0) begin
                    gain_d = gain_q - ENV_W'(1);
                end
            end
        end

        // The oscillator keeps running through the release tail; once the
        // voice is fully silent it is parked at counter 0, phase 0 so the
        // next press always starts from the same point.
        always_ff @(posedge CLOCK_50 or negedge resetn) begin
            if (!resetn) begin
                gain_q  <= '0;
                cnt_q   <= '0;
                phase_q <= 1'b0;
            end else begin
                gain_q <= gain_d;
                if (HP_ZERO || (!keys_s_q[k] && gain_q == '0)) begin
                    cnt_q   <= '0;
                    phase_q <= 1'b0;
                end else if (cnt_q == HP) begin
                    cnt_q   <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    cnt_q <= cnt_q + HP_W'(1);
                end
            end
        end

        assign level = MIX_W'(gain_q) << AMP_SHIFT;
        // A disabled oscillator contributes nothing, even with gain up.
        assign contrib[k] = (HP_ZERO || gain_q == '0) ? '0
                          : (phase_q ? level : -level);
        assign active_voices[k] = (gain_q != '0);
    end

    // ------------------------------------------------------------------
    // Mix with saturation
    // ------------------------------------------------------------------
    logic signed [MIX_W-1:0] mix_sum;
    logic [SAMPLE_W-1:0]     mix_d, mix_q;

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            mix_sum = mix_sum + $signed(contrib[i]);
        end
    end

    always_comb begin
        if (mix_sum > SAT_MAX) begin
            mix_d = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (mix_sum < SAT_MIN) begin
            mix_d = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end else begin
            mix_d = mix_sum[SAMPLE_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Sample pacing and handshake
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]    tick_cnt_q;
    logic                tick;
    logic                grant;
    logic [SAMPLE_W-1:0] sample_q;
    logic                pending_q;
    logic                overrun_q;

    assign tick  = (tick_cnt_q == DIV_W'(SAMPLE_DIV - 1));
    assign grant = pending_q & audio_out_allowed;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            mix_q      <= '0;
            tick_cnt_q <= '0;
            sample_q   <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            mix_q      <= mix_d;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + DIV_W'(1);
            if (tick) begin
                // A grant in the same cycle still writes the old sample, so
                // only an unwritten pending sample counts as lost.
                sample_q  <= mix_q;
                pending_q <= 1'b1;
                if (pending_q && !grant) overrun_q <= 1'b1;
            end else if (grant) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign left_channel_audio_out  = sample_q;
    assign right_channel_audio_out = sample_q;
    assign write_audio_out         = grant;
    assign overrun                 = overrun_q;

endmodule

// File: tb/tb_poly_tone_synth.sv
// ---------------------------------------------------------------------------
// tb_poly_tone_synth
// Two instances share stimulus: one with a small amplitude shift for normal
// operation and one with a large shift so the mix saturates. A reference model
// describes each voice by how long it has been running and the envelope and
// sample pacing by the cycle count since reset.
// ---------------------------------------------------------------------------
module tb_poly_tone_synth;

    localparam int NK = 4;
    localparam int ENV_STEP = 4;
    localparam int SAMPLE_DIV = 8;
    localparam int GMAX = 3;

    int     hp_tb  [NK] = '{3, 5, 7, 0};
    int     shift_tb[2] = '{4, 29};

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  keys;
    logic        allowed;

    logic [31:0] left_a, right_a, left_b, right_b;
    logic        wr_a, wr_b, ovr_a, ovr_b;
    logic [3:0]  act_a, act_b;

    always #5 clk = ~clk;

    poly_tone_synth #(
        .N_KEYS(4), .HP_W(19), .HALF_PERIODS({19'd0, 19'd7, 19'd5, 19'd3}),
        .ENV_W(2), .ENV_STEP(ENV_STEP), .AMP_SHIFT(4), .SAMPLE_W(32), .SAMPLE_DIV(SAMPLE_DIV)
    ) u_dut_a (
        .CLOCK_50(clk), .resetn(resetn), .keys(keys), .audio_out_allowed(allowed),
        .left_channel_audio_out(left_a), .right_channel_audio_out(right_a),
        .write_audio_out(wr_a), .overrun(ovr_a), .active_voices(act_a)
    );

    poly_tone_synth #(
        .N_KEYS(4), .HP_W(19), .HALF_PERIODS({19'd0, 19'd7, 19'd5, 19'd3}),
        .ENV_W(2), .ENV_STEP(ENV_STEP), .AMP_SHIFT(29), .SAMPLE_W(32), .SAMPLE_DIV(SAMPLE_DIV)
    ) u_dut_b (
        .CLOCK_50(clk), .resetn(resetn), .keys(keys), .audio_out_allowed(allowed),
        .left_channel_audio_out(left_b), .right_channel_audio_out(right_b),
        .write_audio_out(wr_b), .overrun(ovr_b), .active_voices(act_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_cyc;
    logic [3:0] m_p1, m_p2;
    int         m_gain[NK];
    int         m_age[NK];
    longint     m_mix[2];
    longint     m_sample[2];
    bit         m_pending, m_overrun;

    task automatic model_reset();
        m_cyc = 0; m_p1 = '0; m_p2 = '0;
        for (int k = 0; k < NK; k++) begin m_gain[k] = 0; m_age[k] = 0; end
        for (int s = 0; s < 2; s++) begin m_mix[s] = 0; m_sample[s] = 0; end
        m_pending = 0; m_overrun = 0;
    endtask

    function automatic longint clamp32(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    // One clock edge of the model.
    task automatic model_step();
        logic [3:0] ks;
        bit         strobe, tick, grant, ph, run;
        longint     sum[2];
        ks     = m_p2;
        strobe = (m_cyc % ENV_STEP) == ENV_STEP - 1;
        tick   = (m_cyc % SAMPLE_DIV) == SAMPLE_DIV - 1;
        sum[0] = 0; sum[1] = 0;
        for (int k = 0; k < NK; k++) begin
            // A tone with half period hp flips every hp+1 clocks of run time.
            ph = (hp_tb[k] != 0) && (((m_age[k] / (hp_tb[k] + 1)) % 2) == 1);
            if (hp_tb[k] != 0 && m_gain[k] > 0)
                for (int s = 0; s < 2; s++)
                    sum[s] += ph ? (longint'(m_gain[k]) <<< shift_tb[s])
                                 : -(longint'(m_gain[k]) <<< shift_tb[s]);
            run = ks[k] || (m_gain[k] > 0);
            m_age[k] = run ? m_age[k] + 1 : 0;
            if (strobe) begin
                if (ks[k]) m_gain[k] = (m_gain[k] < GMAX) ? m_gain[k] + 1 : GMAX;
                else       m_gain[k] = (m_gain[k] > 0) ? m_gain[k] - 1 : 0;
            end
        end
        grant = m_pending && allowed;
        if (tick) begin
            if (m_pending && !grant) m_overrun = 1;
            for (int s = 0; s < 2; s++) m_sample[s] = m_mix[s];
            m_pending = 1;
        end else if (grant) begin
            m_pending = 0;
        end
        for (int s = 0; s < 2; s++) m_mix[s] = clamp32(sum[s]);
        m_p2 = m_p1; m_p1 = keys;
        m_cyc++;
    endtask

    task automatic compare_all();
        logic [3:0]  exp_act;
        logic [31:0] exp_a, exp_b;
        exp_act = '0;
        for (int k = 0; k < NK; k++) exp_act[k] = (m_gain[k] > 0);
        exp_a = 32'(m_sample[0]);
        exp_b = 32'(m_sample[1]);
        check_val("left_a",   64'(left_a),  64'(exp_a));
        check_val("right_a",  64'(right_a), 64'(exp_a));
        check_val("left_b",   64'(left_b),  64'(exp_b));
        check_val("right_b",  64'(right_b), 64'(exp_b));
        check_val("write_a",  64'(wr_a),    64'(m_pending && allowed));
        check_val("write_b",  64'(wr_b),    64'(m_pending && allowed));
        check_val("overrun_a", 64'(ovr_a),  64'(m_overrun));
        check_val("overrun_b", 64'(ovr_b),  64'(m_overrun));
        check_val("active_a", 64'(act_a),   64'(exp_act));
        check_val("active_b", 64'(act_b),   64'(exp_act));
    endtask

    task automatic run_cycle(input logic [3:0] k, input logic a);
        @(negedge clk);
        keys = k; allowed = a;
        #1;
        compare_all();
        @(posedge clk);
        if (resetn) model_step();
    endtask

    // Asserted just after a clock edge, so it lands mid-cycle.
    task automatic mid_reset();
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_val("rst_left_a",  64'(left_a), 64'd0);
        check_val("rst_left_b",  64'(left_b), 64'd0);
        check_val("rst_write",   64'(wr_a),   64'd0);
        check_val("rst_active",  64'(act_a),  64'd0);
        check_val("rst_overrun", 64'(ovr_a),  64'd0);
        run_cycle(keys, allowed);
        run_cycle(keys, allowed);
        #2 resetn = 1'b1;
    endtask

    initial begin
        int seg_len;
        logic [3:0] rk;
        logic ra;
        resetn = 1'b0; keys = '0; allowed = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;

        repeat (6)  run_cycle(4'b0000, 1'b1);   // silence, first tick
        repeat (60) run_cycle(4'b0001, 1'b1);   // attack to full gain on key 0
        check_val("key0_full_gain", 64'(act_a), 64'h1);
        repeat (40) run_cycle(4'b0000, 1'b1);   // release to silence
        check_val("released_silent", 64'(left_a), 64'd0);
        repeat (8)  run_cycle(4'b0001, 1'b1);   // re-press
        repeat (60) run_cycle(4'b0111, 1'b1);   // three voices, saturating in dut b
        repeat (40) run_cycle(4'b0000, 1'b1);
        repeat (40) run_cycle(4'b1000, 1'b1);   // zero half-period voice
        repeat (20) run_cycle(4'b1000, 1'b0);   // stalled consumer
        check_val("overrun_set", 64'(ovr_a), 64'd1);
        repeat (16) run_cycle(4'b0001, 1'b1);
        mid_reset();                            // reset while key 0 is at full gain
        repeat (20) run_cycle(4'b0000, 1'b1);

        for (int seg = 0; seg < 150; seg++) begin
            seg_len = $urandom_range(1, 30);
            rk = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 4) != 0);
            for (int i = 0; i < seg_len; i++) run_cycle(rk, ra);
            if (seg == 75) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
